// File: rtl/pix_stats.sv
// Per-frame RGB444 statistics: per-channel max/min over a frame of num_pix pixels.
// Defining PIX_STATS_CNT_EN adds the pix_cnt output (accepted pixels of the last frame).
module pix_stats #(
  parameter int NPIX_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clr,
  input  logic [NPIX_W-1:0] num_pix,
  input  logic              pix_vld,
  input  logic [11:0]       pix_in,
  output logic              pix_rdy,
  output logic [11:0]       max,
  output logic [11:0]       min,
  output logic              done,
  output logic              busy
`ifdef PIX_STATS_CNT_EN
  ,
  output logic [NPIX_W-1:0] pix_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state_q, state_d;
  logic [NPIX_W-1:0] numPix_q, numPix_d;
  logic [NPIX_W-1:0] cnt_q, cnt_d;
  logic [11:0]       runMax_q, runMax_d;
  logic [11:0]       runMin_q, runMin_d;
  logic [11:0]       max_q, max_d;
  logic [11:0]       min_q, min_d;
  logic              pixRdy_q, pixRdy_d;
  logic              accept;

  // clr wins over everything; each 4-bit channel is compared on its own.
  always_comb begin
    state_d  = state_q;
    numPix_d = numPix_q;
    cnt_d    = cnt_q;
    runMax_d = runMax_q;
    runMin_d = runMin_q;
    accept   = pix_vld & pixRdy_q & ~clr;
    if (clr) begin
      state_d  = IDLE;
      cnt_d    = '0;
      runMax_d = 12'h000;
      runMin_d = 12'hFFF;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            numPix_d = num_pix;
            cnt_d    = '0;
            runMax_d = 12'h000;
            runMin_d = 12'hFFF;
            state_d  = (num_pix == '0) ? DONE : SCAN;
          end
        end
        SCAN: begin
          if (accept) begin
            for (int c = 0; c < 3; c++) begin
              if (pix_in[c*4 +: 4] > runMax_q[c*4 +: 4]) runMax_d[c*4 +: 4] = pix_in[c*4 +: 4];
              if (pix_in[c*4 +: 4] < runMin_q[c*4 +: 4]) runMin_d[c*4 +: 4] = pix_in[c*4 +: 4];
            end
            cnt_d = cnt_q + NPIX_W'(1);
            if (cnt_d == numPix_q) state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Results are loaded on the edge entering DONE so they appear together with done.
  always_comb begin
    max_d    = (state_d == DONE) ? runMax_d : max_q;
    min_d    = (state_d == DONE) ? runMin_d : min_q;
    pixRdy_d = (state_d == SCAN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      numPix_q <= '0;
      cnt_q    <= '0;
      runMax_q <= 12'h000;
      runMin_q <= 12'hFFF;
      max_q    <= 12'h000;
      min_q    <= 12'hFFF;
      pixRdy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      numPix_q <= numPix_d;
      cnt_q    <= cnt_d;
      runMax_q <= runMax_d;
      runMin_q <= runMin_d;
      max_q    <= max_d;
      min_q    <= min_d;
      pixRdy_q <= pixRdy_d;
    end
  end

`ifdef PIX_STATS_CNT_EN
  logic [NPIX_W-1:0] pixCnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixCnt_q <= '0;
    end else if (state_d == DONE) begin
      pixCnt_q <= cnt_d;
    end
  end

  assign pix_cnt = pixCnt_q;
`endif

  assign pix_rdy = pixRdy_q;
  assign max     = max_q;
  assign min     = min_q;
  assign done    = (state_q == DONE);
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_pix_stats.sv
// Self-checking bench for pix_stats: directed frames plus random traffic against
// a frame-level reference model (pixel queue, stats computed on completion).
module tb_pix_stats;

  localparam int NPIX_W = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic              clr;
  logic [NPIX_W-1:0] num_pix;
  logic              pix_vld;
  logic [11:0]       pix_in;
  logic              pix_rdy;
  logic [11:0]       max;
  logic [11:0]       min;
  logic              done;
  logic              busy;
`ifdef PIX_STATS_CNT_EN
  logic [NPIX_W-1:0] pix_cnt;
`endif

  pix_stats #(.NPIX_W(NPIX_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .clr     (clr),
    .num_pix (num_pix),
    .pix_vld (pix_vld),
    .pix_in  (pix_in),
    .pix_rdy (pix_rdy),
    .max     (max),
    .min     (min),
    .done    (done),
    .busy    (busy)
`ifdef PIX_STATS_CNT_EN
    ,
    .pix_cnt (pix_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: mode of the frame, the pixels accepted so far, last results.
  typedef enum {M_IDLE, M_SCAN, M_DONE} mode_t;
  mode_t       mMode;
  logic [11:0] mQ[$];
  int          mTarget;
  logic [11:0] eMax;
  logic [11:0] eMin;
  int          eCnt;

  int accCount;
  int doneCount;
  int rdySeen;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mMode = M_IDLE;
    mQ.delete();
    mTarget = 0;
    eMax = 12'h000;
    eMin = 12'hFFF;
    eCnt = 0;
  endtask

  task automatic frameStats();
    int mx[3];
    int mn[3];
    for (int c = 0; c < 3; c++) begin
      mx[c] = 0;
      mn[c] = 15;
    end
    foreach (mQ[i]) begin
      for (int c = 0; c < 3; c++) begin
        int nib;
        nib = int'((mQ[i] >> (4 * c)) & 12'hF);
        if (nib > mx[c]) mx[c] = nib;
        if (nib < mn[c]) mn[c] = nib;
      end
    end
    eMax = 12'((mx[2] << 8) | (mx[1] << 4) | mx[0]);
    eMin = 12'((mn[2] << 8) | (mn[1] << 4) | mn[0]);
    eCnt = mQ.size();
  endtask

  task automatic modelStep(input logic st, input logic cl, input logic [NPIX_W-1:0] np,
                           input logic v, input logic [11:0] px);
    if (cl) begin
      mMode = M_IDLE;
      mQ.delete();
    end else begin
      case (mMode)
        M_IDLE: if (st) begin
          mQ.delete();
          mTarget = int'(np);
          if (np == 0) begin
            mMode = M_DONE;
            frameStats();
          end else begin
            mMode = M_SCAN;
          end
        end
        M_SCAN: if (v) begin
          mQ.push_back(px);
          if (mQ.size() == mTarget) begin
            mMode = M_DONE;
            frameStats();
          end
        end
        default: mMode = M_IDLE;
      endcase
    end
  endtask

  task automatic compareAll();
    checkOutput("pix_rdy", 32'(pix_rdy), 32'(mMode == M_SCAN));
    checkOutput("busy",    32'(busy),    32'(mMode != M_IDLE));
    checkOutput("done",    32'(done),    32'(mMode == M_DONE));
    checkOutput("max",     32'(max),     32'(eMax));
    checkOutput("min",     32'(min),     32'(eMin));
`ifdef PIX_STATS_CNT_EN
    checkOutput("pix_cnt", 32'(pix_cnt), 32'(eCnt));
`endif
  endtask

  // One cycle: check the current outputs, then drive inputs for the next rising edge.
  task automatic applyStimulus(input logic st, input logic cl, input logic [NPIX_W-1:0] np,
                               input logic v, input logic [11:0] px);
    @(negedge clk);
    compareAll();
    if (pix_rdy && v && !cl) accCount++;
    if (done) doneCount++;
    if (pix_rdy) rdySeen++;
    start   = st;
    clr     = cl;
    num_pix = np;
    pix_vld = v;
    pix_in  = px;
    modelStep(st, cl, np, v, px);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 12'h000);
  endtask

  task automatic clearCounters();
    accCount  = 0;
    doneCount = 0;
    rdySeen   = 0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    start   = 1'b0;
    clr     = 1'b0;
    pix_vld = 1'b0;
    rst     = 1'b1;
    #1;
    checkOutput("rst_pix_rdy", 32'(pix_rdy), 32'd0);
    checkOutput("rst_busy",    32'(busy),    32'd0);
    checkOutput("rst_done",    32'(done),    32'd0);
    checkOutput("rst_max",     32'(max),     32'h000);
    checkOutput("rst_min",     32'(min),     32'hFFF);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    clr     = 1'b0;
    num_pix = '0;
    pix_vld = 1'b0;
    pix_in  = '0;
    modelReset();
    clearCounters();
    #2;
    checkOutput("init_pix_rdy", 32'(pix_rdy), 32'd0);
    checkOutput("init_busy",    32'(busy),    32'd0);
    checkOutput("init_done",    32'(done),    32'd0);
    checkOutput("init_max",     32'(max),     32'h000);
    checkOutput("init_min",     32'(min),     32'hFFF);
    @(negedge clk);
    rst = 1'b0;
    idleCycles(2);

    // Three-pixel frame with pix_vld held high.
    clearCounters();
    applyStimulus(1'b1, 1'b0, 16'd3, 1'b0, 12'h000);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 12'h123);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 12'hA0F);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 12'h5C1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 12'h000);
    checkOutput("f3_done", 32'(done), 32'd1);
    checkOutput("f3_max",  32'(max),  32'hACF);
    checkOutput("f3_min",  32'(min),  32'h101);
`ifdef PIX_STATS_CNT_EN
    checkOutput("f3_cnt",  32'(pix_cnt), 32'd3);
`endif
    idleCycles(2);

    // Four pixels with pix_vld toggling, then extra valid cycles after done.
    clearCounters();
    applyStimulus(1'b1, 1'b0, 16'd4, 1'b0, 12'h000);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, '0, ~i[0], 12'($urandom));
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 12'($urandom));
    checkOutput("tog_accepts", 32'(accCount),  32'd4);
    checkOutput("tog_dones",   32'(doneCount), 32'd1);

    // Empty frame completes on the next cycle.
    clearCounters();
    applyStimulus(1'b1, 1'b0, 16'd0, 1'b1, 12'h777);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 12'h777);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_max",  32'(max),  32'h000);
    checkOutput("zero_min",  32'(min),  32'hFFF);
    idleCycles(2);
    checkOutput("zero_rdy_seen", 32'(rdySeen), 32'd0);

    // Frame with known result, then a second frame aborted by clr mid-scan.
    applyStimulus(1'b1, 1'b0, 16'd2, 1'b0, 12'h000);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 12'h111);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 12'hCCC);
    idleCycles(2);
    clearCounters();
    applyStimulus(1'b1, 1'b0, 16'd5, 1'b0, 12'h000);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 12'hFFF);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 12'h000);
    applyStimulus(1'b1, 1'b1, 16'd2, 1'b1, 12'hF0F);
    idleCycles(3);
    checkOutput("clr_accepts", 32'(accCount),  32'd2);
    checkOutput("clr_dones",   32'(doneCount), 32'd0);
    checkOutput("clr_max",     32'(max),       32'hCCC);
    checkOutput("clr_min",     32'(min),       32'h111);
    checkOutput("clr_busy",    32'(busy),      32'd0);

    // Asynchronous reset in the middle of a scan, then start together with clr.
    applyStimulus(1'b1, 1'b0, 16'd5, 1'b0, 12'h000);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 12'h9A4);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 12'h3E7);
    pulseReset();
    applyStimulus(1'b1, 1'b1, 16'd3, 1'b0, 12'h000);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 12'h000);
    checkOutput("stclr_busy", 32'(busy), 32'd0);
    idleCycles(1);

    // A start during SCAN must not restart or resize the frame.
    clearCounters();
    applyStimulus(1'b1, 1'b0, 16'd5, 1'b0, 12'h000);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 12'h482);
    applyStimulus(1'b1, 1'b0, 16'd9, 1'b1, 12'h1D6);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 12'($urandom));
    checkOutput("ign_accepts", 32'(accCount),  32'd5);
    checkOutput("ign_dones",   32'(doneCount), 32'd1);

    // Random traffic: starts, clears and valid patterns in any state.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3,
                    NPIX_W'($urandom_range(0, 6)), $urandom_range(0, 99) < 60,
                    12'($urandom));
    end
    idleCycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
